// File: rtl/zet_wb_arbiter.sv
// Two-master Wishbone arbiter for the Zet core: exec has priority, fetch is protected
// from starvation, and a watchdog terminates transfers the slave never acknowledges.
module zet_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // fetch master
    input  logic [19:1] wbf_adr_i,
    input  logic [1:0]  wbf_sel_i,
    input  logic        wbf_cyc_i,
    input  logic        wbf_stb_i,
    output logic [15:0] wbf_dat_o,
    output logic        wbf_ack_o,
    // exec master
    input  logic [19:1] wbe_adr_i,
    input  logic [15:0] wbe_dat_i,
    input  logic        wbe_we_i,
    input  logic        wbe_tga_i,
    input  logic [1:0]  wbe_sel_i,
    input  logic        wbe_cyc_i,
    input  logic        wbe_stb_i,
    output logic [15:0] wbe_dat_o,
    output logic        wbe_ack_o,
    // system bus
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [15:0] wb_dat_o,
    output logic [19:1] wb_adr_o,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        to_err_o
);

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam bit          TO_EN      = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST    = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic [15:0] to_cnt_reg, to_cnt_next;
    logic        to_err_reg;
    logic [19:1] adr_reg, adr_next;
    logic [1:0]  sel_reg, sel_next;
    logic [15:0] dat_reg, dat_next;
    logic        we_reg, we_next;
    logic        tga_reg, tga_next;

    logic req_f, req_e, granted, to_hit, done;

    assign req_f   = wbf_cyc_i & wbf_stb_i;
    assign req_e   = wbe_cyc_i & wbe_stb_i;
    assign granted = (state_reg != IDLE);
    assign to_hit  = TO_EN & granted & (to_cnt_reg == TO_LAST) & ~wb_ack_i;
    assign done    = wb_ack_i | to_hit;

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        adr_next        = adr_reg;
        sel_next        = sel_reg;
        dat_next        = dat_reg;
        we_next         = we_reg;
        tga_next        = tga_reg;
        case (state_reg)
            IDLE: begin
                if (req_e && !(req_f && starve_cnt_reg == STARVE_LIM)) begin
                    state_next  = EXEC;
                    to_cnt_next = 16'd0;
                    adr_next    = wbe_adr_i;
                    sel_next    = wbe_sel_i;
                    dat_next    = wbe_dat_i;
                    we_next     = wbe_we_i;
                    tga_next    = wbe_tga_i;
                    if (!req_f)
                        starve_cnt_next = 4'd0;
                    else if (starve_cnt_reg < STARVE_LIM)
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                end else if (req_f) begin
                    state_next      = FETCH;
                    to_cnt_next     = 16'd0;
                    starve_cnt_next = 4'd0;
                    adr_next        = wbf_adr_i;
                    sel_next        = wbf_sel_i;
                    dat_next        = 16'd0;
                    we_next         = 1'b0;
                    tga_next        = 1'b0;
                end else begin
                    starve_cnt_next = 4'd0;
                end
            end
            FETCH: begin
                // A dropped cyc is an abort: release the bus without acking.
                if (done || !wbf_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 16'd1;
                    adr_next    = wbf_adr_i;
                    sel_next    = wbf_sel_i;
                end
            end
            EXEC: begin
                if (done || !wbe_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 16'd1;
                    adr_next    = wbe_adr_i;
                    sel_next    = wbe_sel_i;
                    dat_next    = wbe_dat_i;
                    we_next     = wbe_we_i;
                    tga_next    = wbe_tga_i;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            to_cnt_reg     <= 16'd0;
            to_err_reg     <= 1'b0;
            adr_reg        <= '0;
            sel_reg        <= 2'b00;
            dat_reg        <= 16'd0;
            we_reg         <= 1'b0;
            tga_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            to_err_reg     <= to_hit;
            adr_reg        <= adr_next;
            sel_reg        <= sel_next;
            dat_reg        <= dat_next;
            we_reg         <= we_next;
            tga_reg        <= tga_next;
        end
    end

    assign wb_cyc_o  = granted;
    assign wb_stb_o  = granted;
    assign wb_adr_o  = adr_reg;
    assign wb_sel_o  = sel_reg;
    assign wb_dat_o  = dat_reg;
    assign wb_we_o   = we_reg;
    assign wb_tga_o  = tga_reg;
    assign to_err_o  = to_err_reg;

    assign wbf_ack_o = (state_reg == FETCH) & done;
    assign wbe_ack_o = (state_reg == EXEC) & done;
    // A watchdog-terminated read returns all ones to the master it was granted to.
    assign wbf_dat_o = ((state_reg == FETCH) && to_hit) ? 16'hFFFF : wb_dat_i;
    assign wbe_dat_o = ((state_reg == EXEC) && to_hit) ? 16'hFFFF : wb_dat_i;

endmodule

// File: tb/tb_zet_wb_arbiter.sv
// Directed bench for zet_wb_arbiter (STARVE_MAX=4, TIMEOUT=8); inputs change at
// posedge+1, outputs are compared at the falling edge.
module tb_zet_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [19:1] wbf_adr_i = '0;
    logic [1:0]  wbf_sel_i = '0;
    logic        wbf_cyc_i = 1'b0;
    logic        wbf_stb_i = 1'b0;
    logic [15:0] wbf_dat_o;
    logic        wbf_ack_o;
    logic [19:1] wbe_adr_i = '0;
    logic [15:0] wbe_dat_i = '0;
    logic        wbe_we_i = 1'b0;
    logic        wbe_tga_i = 1'b0;
    logic [1:0]  wbe_sel_i = '0;
    logic        wbe_cyc_i = 1'b0;
    logic        wbe_stb_i = 1'b0;
    logic [15:0] wbe_dat_o;
    logic        wbe_ack_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack_i;
    logic [15:0] wb_dat_o;
    logic [19:1] wb_adr_o;
    logic        wb_we_o;
    logic        wb_tga_o;
    logic [1:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        to_err_o;

    logic ack_force = 1'b0;
    logic auto_ack  = 1'b0;
    assign wb_ack_i = ack_force | (auto_ack & wb_cyc_o);

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    zet_wb_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wbf_adr_i(wbf_adr_i), .wbf_sel_i(wbf_sel_i), .wbf_cyc_i(wbf_cyc_i),
        .wbf_stb_i(wbf_stb_i), .wbf_dat_o(wbf_dat_o), .wbf_ack_o(wbf_ack_o),
        .wbe_adr_i(wbe_adr_i), .wbe_dat_i(wbe_dat_i), .wbe_we_i(wbe_we_i),
        .wbe_tga_i(wbe_tga_i), .wbe_sel_i(wbe_sel_i), .wbe_cyc_i(wbe_cyc_i),
        .wbe_stb_i(wbe_stb_i), .wbe_dat_o(wbe_dat_o), .wbe_ack_o(wbe_ack_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_dat_o(wb_dat_o),
        .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
        .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .to_err_o(to_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic fetch_req(input logic on, input logic [19:1] adr);
        wbf_cyc_i = on;
        wbf_stb_i = on;
        wbf_adr_i = adr;
        wbf_sel_i = 2'b11;
    endtask

    task automatic exec_req(input logic on, input logic [19:1] adr, input logic [15:0] dat,
                            input logic we, input logic tga, input logic [1:0] sel);
        wbe_cyc_i = on;
        wbe_stb_i = on;
        wbe_adr_i = adr;
        wbe_dat_i = dat;
        wbe_we_i  = we;
        wbe_tga_i = tga;
        wbe_sel_i = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // reset state
        step(); step();
        mid();
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_acks", {wbf_ack_o, wbe_ack_o, to_err_o}, 0);
        step();
        rst_i = 1'b1;

        // single fetch read with two wait states, then a late ack in IDLE
        step();
        fetch_req(1'b1, 19'h7FFF0);
        mid();
        check("f_cyc_pre", wb_cyc_o, 0);
        step(); mid();
        check("f_cyc", {wb_cyc_o, wb_stb_o}, 2'b11);
        check("f_we", wb_we_o, 0);
        check("f_adr", wb_adr_o, 19'h7FFF0);
        check("f_ack_w1", wbf_ack_o, 0);
        step(); mid();
        check("f_ack_w2", wbf_ack_o, 0);
        step();
        ack_force = 1'b1;
        wb_dat_i  = 16'hEA5B;
        mid();
        check("f_ack", wbf_ack_o, 1);
        check("f_dat", wbf_dat_o, 16'hEA5B);
        check("f_eack", wbe_ack_o, 0);
        step();
        fetch_req(1'b0, 19'h0);
        mid();
        check("f_cyc_drop", wb_cyc_o, 0);
        check("late_ack", {wbf_ack_o, wbe_ack_o}, 0);

        // exec io write, zero-wait
        step();
        ack_force = 1'b0;
        exec_req(1'b1, 19'h00020, 16'h1234, 1'b1, 1'b1, 2'b01);
        mid();
        step();
        ack_force = 1'b1;
        mid();
        check("e_adr", wb_adr_o, 19'h00020);
        check("e_dat", wb_dat_o, 16'h1234);
        check("e_sel", wb_sel_o, 2'b01);
        check("e_we_tga", {wb_we_o, wb_tga_o}, 2'b11);
        check("e_ack", wbe_ack_o, 1);
        check("e_fack", wbf_ack_o, 0);
        step();
        ack_force = 1'b0;
        exec_req(1'b0, 19'h0, 16'h0, 1'b0, 1'b0, 2'b00);
        mid();
        check("e_cyc_drop", wb_cyc_o, 0);

        // starvation: both masters request continuously, zero-wait slave
        step();
        exec_req(1'b1, 19'h00100, 16'hAAAA, 1'b1, 1'b0, 2'b11);
        fetch_req(1'b1, 19'h00200);
        auto_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int obs_k;
            int exp_k;
            mid();
            obs_k = !wb_cyc_o ? 0 : (wb_we_o ? 1 : 2);
            if (i % 2 == 0) exp_k = 0;
            else exp_k = (((i - 1) / 2) % 5 == 4) ? 2 : 1;
            check($sformatf("starve_c%0d", i), obs_k, exp_k);
            step();
        end
        exec_req(1'b0, 19'h0, 16'h0, 1'b0, 1'b0, 2'b00);
        fetch_req(1'b0, 19'h0);
        auto_ack = 1'b0;
        mid();
        check("starve_end", wb_cyc_o, 0);

        // watchdog on an exec read with fetch pending
        step();
        exec_req(1'b1, 19'h00055, 16'h0, 1'b0, 1'b0, 2'b11);
        fetch_req(1'b1, 19'h00066);
        wb_dat_i = 16'h1234;
        mid();
        step();
        for (int c = 1; c <= 8; c++) begin
            mid();
            if (c < 8) begin
                check($sformatf("to_wait%0d", c), {wbe_ack_o, to_err_o}, 0);
                step();
            end
        end
        check("to_ack", wbe_ack_o, 1);
        check("to_dat", wbe_dat_o, 16'hFFFF);
        check("to_fack", wbf_ack_o, 0);
        check("to_err_early", to_err_o, 0);
        step();
        exec_req(1'b0, 19'h0, 16'h0, 1'b0, 1'b0, 2'b00);
        mid();
        check("to_err", to_err_o, 1);
        check("to_cyc_drop", wb_cyc_o, 0);
        step(); mid();
        check("to_fgrant", {wb_cyc_o, wb_we_o}, 2'b10);
        check("to_fadr", wb_adr_o, 19'h00066);
        check("to_err_clr", to_err_o, 0);
        step();
        ack_force = 1'b1;
        mid();
        check("to_fdone", wbf_ack_o, 1);
        check("to_fdat", wbf_dat_o, 16'h1234);
        step();
        ack_force = 1'b0;
        fetch_req(1'b0, 19'h0);

        // asynchronous reset during a fetch transfer
        step();
        fetch_req(1'b1, 19'h00003);
        mid();
        step(); mid();
        check("r_cyc_pre", wb_cyc_o, 1);
        #2;
        rst_i = 1'b0;
        ack_force = 1'b1;
        #1;
        check("r_cyc", {wb_cyc_o, wb_stb_o}, 0);
        check("r_adr", wb_adr_o, 0);
        check("r_noack", {wbf_ack_o, wbe_ack_o, to_err_o}, 0);
        mid();
        ack_force = 1'b0;
        #2;
        rst_i = 1'b1;
        step(); mid();
        check("r_regrant", wb_cyc_o, 1);
        check("r_adr2", wb_adr_o, 19'h00003);
        step();
        ack_force = 1'b1;
        mid();
        check("r_ack", wbf_ack_o, 1);
        step();
        ack_force = 1'b0;
        fetch_req(1'b0, 19'h0);

        // exec abort after one wait cycle
        step();
        exec_req(1'b1, 19'h00077, 16'h0, 1'b0, 1'b0, 2'b11);
        mid();
        step(); mid();
        check("a_cyc", wb_cyc_o, 1);
        check("a_noack1", wbe_ack_o, 0);
        step();
        wbe_cyc_i = 1'b0;
        wbe_stb_i = 1'b0;
        mid();
        check("a_noack2", wbe_ack_o, 0);
        step(); mid();
        check("a_drop", {wb_cyc_o, wb_stb_o}, 0);
        check("a_noerr", {to_err_o, wbe_ack_o}, 0);
        step(); mid();
        check("a_noerr2", to_err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
